// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the CPU memory stage, the loader port and the single-port
// data memory; the arbiter sits on the slave side.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cpuReq, cpuWe, cpuGnt, cpuStall, cpuRdValid;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuWrData, cpuRdData;

  logic              ldrReq, ldrLock, ldrWe, ldrGnt, ldrRdValid;
  logic [ADDR_W-1:0] ldrAddr;
  logic [DATA_W-1:0] ldrWrData, ldrRdData;

  logic              memWrEnable, memRdEnable;
  logic [ADDR_W-1:0] memWrAddress, memRdAddress;
  logic [DATA_W-1:0] memWrData, memRdData;

  modport slave (
    input  cpuReq, cpuWe, cpuAddr, cpuWrData,
    output cpuGnt, cpuStall, cpuRdValid, cpuRdData,
    input  ldrReq, ldrLock, ldrWe, ldrAddr, ldrWrData,
    output ldrGnt, ldrRdValid, ldrRdData,
    output memWrEnable, memWrAddress, memWrData, memRdEnable, memRdAddress,
    input  memRdData
  );

  modport master (
    output cpuReq, cpuWe, cpuAddr, cpuWrData,
    input  cpuGnt, cpuStall, cpuRdValid, cpuRdData,
    output ldrReq, ldrLock, ldrWe, ldrAddr, ldrWrData,
    input  ldrGnt, ldrRdValid, ldrRdData,
    input  memWrEnable, memWrAddress, memWrData, memRdEnable, memRdAddress,
    output memRdData
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-grant arbiter sharing one data-memory port between the CPU and the loader,
// with round-robin on contention and bounded loader lock bursts.
module dmem_port_arbiter_rdret #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_gnt_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              rd_vld_o,
  output logic [DATA_W-1:0] rd_data_o
);
  logic              vld_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q <= rd_gnt_i;
      if (rd_gnt_i) data_q <= rd_data_i;
    end
  end

  assign rd_vld_o  = vld_q;
  assign rd_data_o = data_q;
endmodule

module dmem_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  dmem_port_arbiter_if.slave bus
);
  localparam int NUM_PORTS = 2;   // 0 = CPU, 1 = loader
  localparam int CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_LDR, S_LOCK} state_e;

  state_e           state_q, state_d;
  logic             last_ldr_q, last_ldr_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             cpu_gnt, ldr_gnt, gnt_any, we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // Grants are forced low during reset so nothing reaches the memory.
  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (rst_n) begin
      if (bus.cpuReq && bus.ldrReq) begin
        if (burst_q == BURST_MAX)  cpu_gnt = 1'b1;
        else if (state_q == S_LOCK) ldr_gnt = 1'b1;
        else if (last_ldr_q)        cpu_gnt = 1'b1;
        else                        ldr_gnt = 1'b1;
      end else begin
        cpu_gnt = bus.cpuReq;
        ldr_gnt = bus.ldrReq;
      end
    end
  end

  // Burst counter only advances while the CPU is actually being held off.
  always_comb begin
    state_d    = S_IDLE;
    last_ldr_d = last_ldr_q;
    burst_d    = '0;
    if (cpu_gnt) begin
      state_d    = S_CPU;
      last_ldr_d = 1'b0;
    end else if (ldr_gnt) begin
      last_ldr_d = 1'b1;
      if (bus.ldrLock) begin
        state_d = S_LOCK;
        burst_d = (bus.cpuReq && burst_q != BURST_MAX) ? burst_q + 1'b1 : burst_q;
      end else begin
        state_d = S_LDR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_ldr_q <= 1'b1;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_ldr_q <= last_ldr_d;
      burst_q    <= burst_d;
    end
  end

  assign gnt_any   = cpu_gnt | ldr_gnt;
  assign we_sel    = cpu_gnt ? bus.cpuWe     : bus.ldrWe;
  assign addr_sel  = cpu_gnt ? bus.cpuAddr   : bus.ldrAddr;
  assign wdata_sel = cpu_gnt ? bus.cpuWrData : bus.ldrWrData;

  assign bus.cpuGnt       = cpu_gnt;
  assign bus.ldrGnt       = ldr_gnt;
  assign bus.cpuStall     = rst_n & bus.cpuReq & ~cpu_gnt;
  assign bus.memWrEnable  = gnt_any & we_sel;
  assign bus.memRdEnable  = gnt_any & ~we_sel;
  assign bus.memWrAddress = bus.memWrEnable ? addr_sel  : '0;
  assign bus.memWrData    = bus.memWrEnable ? wdata_sel : '0;
  assign bus.memRdAddress = bus.memRdEnable ? addr_sel  : '0;

  logic [NUM_PORTS-1:0]             rd_gnt, rd_vld;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;

  assign rd_gnt[0] = cpu_gnt & ~bus.cpuWe;
  assign rd_gnt[1] = ldr_gnt & ~bus.ldrWe;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdret
    dmem_port_arbiter_rdret #(.DATA_W(DATA_W)) u_rdret (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_gnt_i  (rd_gnt[p]),
      .rd_data_i (bus.memRdData),
      .rd_vld_o  (rd_vld[p]),
      .rd_data_o (rd_data[p])
    );
  end

  assign bus.cpuRdValid = rd_vld[0];
  assign bus.cpuRdData  = rd_data[0];
  assign bus.ldrRdValid = rd_vld[1];
  assign bus.ldrRdData  = rd_data[1];
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 1024x32 memory.
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  dmem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [1024] = '{default: '0};
  assign bus.memRdData = mem[bus.memRdAddress];
  always @(posedge clk) if (bus.memWrEnable) mem[bus.memWrAddress] <= bus.memWrData;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv_cpu(input logic req, input logic we, input logic [9:0] a, input logic [31:0] d);
    bus.cpuReq = req; bus.cpuWe = we; bus.cpuAddr = a; bus.cpuWrData = d;
  endtask

  task automatic drv_ldr(input logic req, input logic lock, input logic we, input logic [9:0] a,
                         input logic [31:0] d);
    bus.ldrReq = req; bus.ldrLock = lock; bus.ldrWe = we; bus.ldrAddr = a; bus.ldrWrData = d;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    drv_cpu(0, 0, 0, 0);
    drv_ldr(0, 0, 0, 0, 0);
  endtask

  initial begin
    idle();
    cyc(); cyc();
    #1;
    chk("rst_cpuGnt", bus.cpuGnt, 0);
    chk("rst_ldrGnt", bus.ldrGnt, 0);
    chk("rst_wen", bus.memWrEnable, 0);
    chk("rst_cpuRdValid", bus.cpuRdValid, 0);
    chk("rst_cpuRdData", bus.cpuRdData, 0);
    chk("rst_ldrRdValid", bus.ldrRdValid, 0);
    cyc(); rst_n = 1'b1;

    // CPU-only write then read
    cyc(); drv_cpu(1, 1, 10'h005, 32'h0101_0101); #1;
    chk("t1_wr_gnt", bus.cpuGnt, 1);
    chk("t1_wr_stall", bus.cpuStall, 0);
    chk("t1_wen", bus.memWrEnable, 1);
    chk("t1_waddr", bus.memWrAddress, 10'h005);
    chk("t1_wdata", bus.memWrData, 32'h0101_0101);
    cyc(); drv_cpu(1, 0, 10'h005, 0); #1;
    chk("t1_rd_gnt", bus.cpuGnt, 1);
    chk("t1_ren", bus.memRdEnable, 1);
    chk("t1_raddr", bus.memRdAddress, 10'h005);
    chk("t1_vld_after_wr", bus.cpuRdValid, 0);
    cyc(); idle(); #1;
    chk("t1_rdvalid", bus.cpuRdValid, 1);
    chk("t1_rddata", bus.cpuRdData, 32'h0101_0101);
    cyc(); #1;
    chk("t1_rdvalid_drop", bus.cpuRdValid, 0);
    chk("t1_rddata_hold", bus.cpuRdData, 32'h0101_0101);

    // Contention from reset: CPU first, then alternate
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc(); drv_cpu(1, 0, 10'h005, 0); drv_ldr(1, 0, 0, 10'h005, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_cpuGnt%0d", i), bus.cpuGnt, (i % 2) == 0);
      chk($sformatf("t2_ldrGnt%0d", i), bus.ldrGnt, (i % 2) == 1);
      chk($sformatf("t2_stall%0d", i), bus.cpuStall, (i % 2) == 1);
      cyc();
    end
    idle();

    // Lock burst: one CPU-only cycle so the loader wins the first contested cycle
    drv_cpu(1, 0, 10'h005, 0); #1;
    chk("t3_pre_gnt", bus.cpuGnt, 1);
    cyc(); drv_ldr(1, 1, 0, 10'h005, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t3_ldrGnt%0d", i), bus.ldrGnt, i < 4);
      chk($sformatf("t3_cpuGnt%0d", i), bus.cpuGnt, i == 4);
      chk($sformatf("t3_stall%0d", i), bus.cpuStall, i < 4);
      cyc();
    end
    idle();

    // Loader preload of words 0..7, then CPU read-back
    for (int i = 0; i < 8; i++) begin
      cyc(); drv_ldr(1, 0, 1, 10'(i), 32'h1111_1111 * i); #1;
      chk($sformatf("t4_pre_gnt%0d", i), bus.ldrGnt, 1);
    end
    cyc(); idle();
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drv_cpu(1, 0, 10'(i), 0);
      else       drv_cpu(0, 0, 0, 0);
      #1;
      if (i > 0) begin
        chk($sformatf("t4_vld%0d", i - 1), bus.cpuRdValid, 1);
        chk($sformatf("t4_data%0d", i - 1), bus.cpuRdData, 32'h1111_1111 * (i - 1));
      end
      cyc();
    end

    // Reset in the second cycle of a lock burst
    drv_cpu(1, 0, 10'h200, 0); drv_ldr(1, 1, 1, 10'h200, 32'hAAAA_5555); #1;
    chk("t5_burst1_ldr", bus.ldrGnt, 1);
    cyc(); rst_n = 1'b0; drv_ldr(1, 1, 1, 10'h201, 32'h1234_5678); #1;
    chk("t5_rst_cpuGnt", bus.cpuGnt, 0);
    chk("t5_rst_ldrGnt", bus.ldrGnt, 0);
    chk("t5_rst_stall", bus.cpuStall, 0);
    chk("t5_rst_wen", bus.memWrEnable, 0);
    chk("t5_rst_ren", bus.memRdEnable, 0);
    chk("t5_rst_rddata", bus.cpuRdData, 0);
    cyc();
    chk("t5_no_write", mem[10'h201], 0);
    rst_n = 1'b1; #1;
    chk("t5_post_cpuGnt", bus.cpuGnt, 1);
    chk("t5_post_ldrGnt", bus.ldrGnt, 0);
    cyc(); #1;
    chk("t5_rdvalid", bus.cpuRdValid, 1);
    chk("t5_rddata", bus.cpuRdData, 32'hAAAA_5555);
    chk("t5_next_ldr", bus.ldrGnt, 1);
    cyc(); idle();

    // Lock without request is ignored
    drv_cpu(1, 0, 10'h005, 0); drv_ldr(0, 1, 0, 0, 0); #1;
    chk("t6_lock_noreq", bus.cpuGnt, 1);
    cyc(); idle();

    // Loader read of the top word with the CPU idle
    drv_ldr(1, 0, 1, 10'h3FF, 32'h3FF0_CAFE);
    cyc(); drv_ldr(1, 0, 0, 10'h3FF, 0); #1;
    chk("t7_gnt", bus.ldrGnt, 1);
    chk("t7_raddr", bus.memRdAddress, 10'h3FF);
    cyc(); idle(); #1;
    chk("t7_ldrvld", bus.ldrRdValid, 1);
    chk("t7_ldrdata", bus.ldrRdData, 32'h3FF0_CAFE);
    chk("t7_cpuvld", bus.cpuRdValid, 0);
    cyc(); #1;
    chk("t7_ldrvld_drop", bus.ldrRdValid, 0);
    chk("t7_cpuvld_still", bus.cpuRdValid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
